ro_puf_comparator: RTL and testbench

Parametrised ring-oscillator PUF response generator for an array of NUM_RO externally built oscillators.
- Per request, enables two oscillators chosen by the challenge and counts their synchronised rising edges over a fixed window of clk cycles.
- Repeats the measurement VOTES times and returns the majority comparison bit, with a reliability margin and an instability flag.
- Sits between the oscillator array and the challenge/response host logic, replacing free-running RO-clocked counters with a single-clock, handshaked measurement engine.

---
 rtl/ro_puf_pkg.sv | 23 ++
 rtl/ro_puf_comparator_edge_counter.sv | 46 ++++
 rtl/ro_puf_comparator.sv | 222 ++++++++++++++++++++++
 tb/tb_ro_puf_comparator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF comparator.
//   state_t    : measurement FSM states
//   SETTLE_CYC : cycles the selected oscillators run before each count window
//   params_ok  : elaboration check on VOTES / NUM_RO
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned SETTLE_CYC = 16;

  // VOTES must be odd (so a majority always exists) and NUM_RO a power of two.
  function automatic bit params_ok(input int unsigned votes, input int unsigned num_ro);
    return (votes % 2 == 1) && (votes <= 15) &&
           (num_ro >= 2) && (num_ro <= 64) && ((num_ro & (num_ro - 1)) == 0);
  endfunction

endpackage

// File: rtl/ro_puf_comparator_edge_counter.sv
// Synchronises one asynchronous oscillator output and counts its rising edges.
//   clk, rst_n : system clock, synchronous active-low reset
//   ro_async   : raw oscillator output (asynchronous to clk)
//   clear      : zero the counter
//   count_en   : count detected rising edges while high
//   count      : saturating edge count
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_async,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  // [0],[1] form the synchroniser, [2] delays for edge detection
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise;

  always_comb begin
    sync_d  = {sync_q[1:0], ro_async};
    rise    = sync_q[1] & ~sync_q[2];
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && rise && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ro_puf_comparator.sv
// Handshaked ring-oscillator PUF response engine: compares edge counts of two
// challenge-selected oscillators over VOTES windows and reports the majority.
//   clk, rst_n    : system clock, synchronous active-low reset
//   ro_in         : raw oscillator outputs
//   ro_en         : oscillator enables (only the two selected bits, only while measuring)
//   start         : request strobe, honoured in IDLE only
//   challenge     : {index A, index B}
//   busy          : request in progress
//   resp_valid    : one-cycle response strobe; resp_* held until the next response
//   resp_bit      : majority of countA > countB
//   resp_margin   : smallest |countA - countB| across votes
//   resp_unstable : split vote or any tie
//   err           : challenge selected the same oscillator twice
module ro_puf_comparator
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_RO = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WINDOW = 4096,
  parameter int unsigned VOTES  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RO-1:0]          ro_in,
  output logic [NUM_RO-1:0]          ro_en,
  input  logic                       start,
  input  logic [2*$clog2(NUM_RO)-1:0] challenge,
  output logic                       busy,
  output logic                       resp_valid,
  output logic                       resp_bit,
  output logic [CNT_W-1:0]           resp_margin,
  output logic                       resp_unstable,
  output logic                       err
);

  localparam int unsigned IDX_W = $clog2(NUM_RO);
  localparam int unsigned CYC_W = 20;
  localparam int unsigned VW    = 4;

  if (!params_ok(VOTES, NUM_RO)) begin : g_param_err
    $error("ro_puf_comparator: VOTES must be odd <= 15 and NUM_RO a power of two in 2..64");
  end

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [VW-1:0]      vote_q, vote_d;
  logic [VW-1:0]      tally_q, tally_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic               tie_q, tie_d;
  logic [IDX_W-1:0]   idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic               busy_q, busy_d;
  logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_bit_q, resp_bit_d;
  logic [CNT_W-1:0]   resp_margin_q, resp_margin_d;
  logic               resp_unstable_q, resp_unstable_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   cnt_a, cnt_b, diff;
  logic               vote, measuring;
  logic [IDX_W-1:0]   ch_a, ch_b;

  // Select lines only change in IDLE, so the settle phase flushes stale sync state
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_async (ro_in[idx_a_q]),
    .clear    (state_q == SETTLE),
    .count_en (state_q == COUNT),
    .count    (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_async (ro_in[idx_b_q]),
    .clear    (state_q == SETTLE),
    .count_en (state_q == COUNT),
    .count    (cnt_b)
  );

  assign ch_a = challenge[2*IDX_W-1:IDX_W];
  assign ch_b = challenge[IDX_W-1:0];

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    vote_d          = vote_q;
    tally_d         = tally_q;
    min_d           = min_q;
    tie_d           = tie_q;
    idx_a_d         = idx_a_q;
    idx_b_d         = idx_b_q;
    resp_valid_d    = 1'b0;
    resp_bit_d      = resp_bit_q;
    resp_margin_d   = resp_margin_q;
    resp_unstable_d = resp_unstable_q;
    err_d           = 1'b0;

    vote = (cnt_a > cnt_b);
    diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_a_d = ch_a;
          idx_b_d = ch_b;
          if (ch_a == ch_b) begin
            state_d         = DONE;
            resp_valid_d    = 1'b1;
            err_d           = 1'b1;
            resp_bit_d      = 1'b0;
            resp_margin_d   = '0;
            resp_unstable_d = 1'b0;
          end else begin
            state_d = SETTLE;
            cyc_d   = '0;
            vote_d  = '0;
            tally_d = '0;
            min_d   = {CNT_W{1'b1}};
            tie_d   = 1'b0;
          end
        end
      end
      SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          state_d = COUNT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      COUNT: begin
        if (cyc_q == CYC_W'(WINDOW - 1)) begin
          state_d = COMPARE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      COMPARE: begin
        tally_d = tally_q + VW'(vote);
        vote_d  = vote_q + VW'(1);
        if (diff < min_q) begin
          min_d = diff;
        end
        if (cnt_a == cnt_b) begin
          tie_d = 1'b1;
        end
        if (vote_d == VW'(VOTES)) begin
          state_d         = DONE;
          resp_valid_d    = 1'b1;
          resp_bit_d      = (tally_d > VW'(VOTES / 2));
          resp_margin_d   = min_d;
          resp_unstable_d = tie_d || ((tally_d != '0) && (tally_d != VW'(VOTES)));
        end else begin
          state_d = SETTLE;
          cyc_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = (state_d != IDLE);
    measuring = (state_d == SETTLE) || (state_d == COUNT) || (state_d == COMPARE);
    ro_en_d   = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      ro_en_d[i] = measuring && ((IDX_W'(i) == idx_a_d) || (IDX_W'(i) == idx_b_d));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      vote_q          <= '0;
      tally_q         <= '0;
      min_q           <= '0;
      tie_q           <= 1'b0;
      idx_a_q         <= '0;
      idx_b_q         <= '0;
      busy_q          <= 1'b0;
      ro_en_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_bit_q      <= 1'b0;
      resp_margin_q   <= '0;
      resp_unstable_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      vote_q          <= vote_d;
      tally_q         <= tally_d;
      min_q           <= min_d;
      tie_q           <= tie_d;
      idx_a_q         <= idx_a_d;
      idx_b_q         <= idx_b_d;
      busy_q          <= busy_d;
      ro_en_q         <= ro_en_d;
      resp_valid_q    <= resp_valid_d;
      resp_bit_q      <= resp_bit_d;
      resp_margin_q   <= resp_margin_d;
      resp_unstable_q <= resp_unstable_d;
      err_q           <= err_d;
    end
  end

  assign busy          = busy_q;
  assign ro_en         = ro_en_q;
  assign resp_valid    = resp_valid_q;
  assign resp_bit      = resp_bit_q;
  assign resp_margin   = resp_margin_q;
  assign resp_unstable = resp_unstable_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ro_puf_comparator.sv
// Directed self-checking bench for ro_puf_comparator.
// Three instances: single vote (CNT_W=16), three votes, and single vote with CNT_W=4.
module tb_ro_puf_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ro_vec;
  logic [2:0] start = '0;
  logic [5:0] challenge = '0;

  logic        busy0, rv0, rb0, un0, er0;
  logic [15:0] mg0;
  logic [7:0]  en0;
  logic        busy1, rv1, rb1, un1, er1;
  logic [15:0] mg1;
  logic [7:0]  en1;
  logic        busy2, rv2, rb2, un2, er2;
  logic [3:0]  mg2;
  logic [7:0]  en2;

  // oscillator models: wa on bit 2, wb (or wa when same=1) on bit 5
  logic wa = 1'b0, wb = 1'b0, same = 1'b0;
  int   ha = 20, hb = 30;

  int n_checks = 0, n_fail = 0;
  int sel = 0;
  logic        o_busy, o_rv, o_rb, o_un, o_er;
  logic [15:0] o_mg;
  logic [7:0]  o_en;

  int r_lat, r_bit, r_mg, r_un, r_err, r_en_mid, r_en_done, r_busy_done, r_busy_after;

  always #5 clk = ~clk;

  initial begin #3; forever #(ha) wa = ~wa; end
  initial begin #3; forever #(hb) wb = ~wb; end

  always_comb begin
    ro_vec    = '0;
    ro_vec[2] = wa;
    ro_vec[5] = same ? wa : wb;
  end

  ro_puf_comparator #(.NUM_RO(8), .CNT_W(16), .WINDOW(240), .VOTES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_vec), .ro_en(en0), .start(start[0]),
    .challenge(challenge), .busy(busy0), .resp_valid(rv0), .resp_bit(rb0),
    .resp_margin(mg0), .resp_unstable(un0), .err(er0));

  ro_puf_comparator #(.NUM_RO(8), .CNT_W(16), .WINDOW(240), .VOTES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_vec), .ro_en(en1), .start(start[1]),
    .challenge(challenge), .busy(busy1), .resp_valid(rv1), .resp_bit(rb1),
    .resp_margin(mg1), .resp_unstable(un1), .err(er1));

  ro_puf_comparator #(.NUM_RO(8), .CNT_W(4), .WINDOW(240), .VOTES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_vec), .ro_en(en2), .start(start[2]),
    .challenge(challenge), .busy(busy2), .resp_valid(rv2), .resp_bit(rb2),
    .resp_margin(mg2), .resp_unstable(un2), .err(er2));

  always_comb begin
    case (sel)
      0: begin o_busy = busy0; o_rv = rv0; o_rb = rb0; o_un = un0; o_er = er0; o_mg = mg0; o_en = en0; end
      1: begin o_busy = busy1; o_rv = rv1; o_rb = rb1; o_un = un1; o_er = er1; o_mg = mg1; o_en = en1; end
      default: begin o_busy = busy2; o_rv = rv2; o_rb = rb2; o_un = un2; o_er = er2; o_mg = 16'(mg2); o_en = en2; end
    endcase
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request from a negedge; r_lat counts clk edges from the start edge (k) to resp_valid.
  task automatic do_req(input int d, input int a, input int b);
    int n;
    sel          = d;
    challenge    = 6'(a * 8 + b);
    start[d]     = 1'b1;
    tick();
    start[d]     = 1'b0;
    n            = 1;
    r_en_mid     = 0;
    while (!o_rv && n < 3000) begin
      if (n == 100) r_en_mid = int'(o_en);
      tick();
      n++;
    end
    r_lat        = o_rv ? n : -1;
    r_bit        = int'(o_rb);
    r_mg         = int'(o_mg);
    r_un         = int'(o_un);
    r_err        = int'(o_er);
    r_en_done    = int'(o_en);
    r_busy_done  = int'(o_busy);
    tick();
    r_busy_after = int'(o_busy);
  endtask

  initial begin
    int pulses;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    @(negedge clk);
    tick(); tick();
    sel = 0;
    check("rst_busy", o_busy, 0);
    check("rst_rv", o_rv, 0);
    check("rst_bit", o_rb, 0);
    check("rst_margin", o_mg, 0);
    check("rst_unstable", o_un, 0);
    check("rst_err", o_er, 0);
    check("rst_ro_en", o_en, 0);
    rst_n = 1'b1;
    tick(); tick();

    // A=2 (period 4) vs B=5 (period 6): 60 vs 40 edges
    do_req(0, 2, 5);
    check("a_win_lat", r_lat, 258);
    check("a_win_bit", r_bit, 1);
    check("a_win_margin_rng", (r_mg >= 18 && r_mg <= 22), 1);
    check("a_win_unstable", r_un, 0);
    check("a_win_err", r_err, 0);
    check("a_win_ro_en", r_en_mid, 8'h24);
    check("a_win_ro_en_done", r_en_done, 0);
    check("a_win_busy_done", r_busy_done, 1);
    check("a_win_busy_after", r_busy_after, 0);

    do_req(0, 5, 2);
    check("swap_lat", r_lat, 258);
    check("swap_bit", r_bit, 0);
    check("swap_margin_rng", (r_mg >= 18 && r_mg <= 22), 1);
    check("swap_unstable", r_un, 0);
    check("swap_ro_en", r_en_mid, 8'h24);

    // identical waveform on both channels
    ha = 25; same = 1'b1;
    repeat (10) tick();
    do_req(0, 2, 5);
    check("equal_bit", r_bit, 0);
    check("equal_unstable", r_un, 1);
    check("equal_margin_le1", (r_mg <= 1), 1);
    ha = 20; same = 1'b0;
    repeat (10) tick();

    // CNT_W=4: 60 and 40 edges both clip at 15
    do_req(2, 2, 5);
    check("sat_lat", r_lat, 258);
    check("sat_bit", r_bit, 0);
    check("sat_margin", r_mg, 0);
    check("sat_unstable", r_un, 1);

    // three votes; B speeds up to period 3.6 clk (~67 edges) in vote 2 only
    fork
      do_req(1, 2, 5);
      begin
        repeat (262) @(posedge clk);
        hb = 18;
        repeat (257) @(posedge clk);
        hb = 30;
      end
    join
    check("vote3_lat", r_lat, 772);
    check("vote3_bit", r_bit, 1);
    check("vote3_unstable", r_un, 1);
    check("vote3_margin_rng", (r_mg >= 4 && r_mg <= 9), 1);
    repeat (5) tick();

    // A == B
    do_req(0, 3, 3);
    check("err_lat", r_lat, 1);
    check("err_flag", r_err, 1);
    check("err_bit", r_bit, 0);
    check("err_margin", r_mg, 0);
    check("err_unstable", r_un, 0);
    check("err_ro_en", r_en_done, 0);
    check("err_busy_after", r_busy_after, 0);
    tick();

    // second start while busy must be dropped
    sel = 0; challenge = 6'(2 * 8 + 5); start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 320; n++) begin
      if (o_rv) pulses++;
      start[0] = (n == 10);
      tick();
    end
    start[0] = 1'b0;
    check("busy_start_pulses", pulses, 1);
    check("busy_start_idle", o_busy, 0);

    // reset during COUNT aborts the request
    challenge = 6'(2 * 8 + 5); start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (100) tick();
    check("mid_busy_pre", o_busy, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ro_en", o_en, 0);
    check("mid_rst_rv", o_rv, 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      if (o_rv) pulses++;
      tick();
    end
    check("mid_rst_no_resp", pulses, 0);
    do_req(0, 2, 5);
    check("post_rst_lat", r_lat, 258);
    check("post_rst_bit", r_bit, 1);
    check("post_rst_margin_rng", (r_mg >= 18 && r_mg <= 22), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
